muldiv_sched: RTL and testbench

Sequencer and result buffer for the shared multi-cycle multiplier and divider in the EXE stage of the five-stage MIPS pipeline. It accepts one HI/LO-producing operation at a time from EXE and registers the operands. It drives the multiplier's or the divider's level-held start signal until that unit reports completion, then holds the 64-bit HI/LO result until downstream accepts it. It also handles pipeline flush, divide-by-zero and a watchdog timeout so that a stuck unit cannot hang the pipeline.

---
 rtl/muldiv_sched.sv | 135 +++++++++++++
 tb/tb_muldiv_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - HI/LO operation sequencer for the shared multiplier and divider
// Starts one unit at a time, buffers its 64-bit result, and recovers from flush or a stuck unit.
module muldiv_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] mult_product,
  input  logic        mult_end,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wd_cnt;
  logic [31:0] r_op1, r_op2, r_hi, r_lo;
  logic        r_signed, r_timeout_err;
  logic        w_accept, w_div_op, w_wd_hit, w_timeout;

  assign req_ready  = (r_state == IDLE) & ~flush;
  assign w_accept   = req_valid & req_ready;
  assign w_div_op   = (req_op == 2'b01) | (req_op == 2'b10);
  assign w_wd_hit   = (r_wd_cnt == WD_LAST);

  assign mult_begin   = (r_state == MUL_WAIT);
  assign div_start    = (r_state == DIV_WAIT);
  assign rsp_valid    = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign timeout_err  = r_timeout_err;
  assign mult_op1     = r_op1;
  assign mult_op2     = r_op2;
  assign div_dividend = r_op1;
  assign div_divisor  = r_op2;
  assign div_signed   = r_signed;
  assign rsp_hi       = r_hi;
  assign rsp_lo       = r_lo;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_op == 2'b00)                     w_next = MUL_WAIT;
          else if (w_div_op && req_src2 != 32'd0)  w_next = DIV_WAIT;
          else                                     w_next = DONE;
        end
      end
      MUL_WAIT: begin
        if (mult_end) begin
          w_next = DONE;
        end else if (w_wd_hit) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (div_done) begin
          w_next = DONE;
        end else if (w_wd_hit) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Flush overrides everything, including a completion or timeout in the same cycle.
    if (flush) begin
      w_next    = IDLE;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_wd_cnt      <= 8'd0;
      r_op1         <= 32'd0;
      r_op2         <= 32'd0;
      r_signed      <= 1'b0;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_timeout_err <= w_timeout;
      r_wd_cnt      <= (r_state == MUL_WAIT || r_state == DIV_WAIT) ? r_wd_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_op1    <= req_src1;
        r_op2    <= req_src2;
        r_signed <= (req_op == 2'b10);
        if (req_op == 2'b11) begin
          r_hi <= req_src1;
          r_lo <= req_src2;
        end else if (w_div_op && req_src2 == 32'd0) begin
          r_hi <= req_src1;
          r_lo <= 32'hFFFF_FFFF;
        end
      end
      if (!flush && r_state == MUL_WAIT && mult_end) begin
        r_hi <= mult_product[63:32];
        r_lo <= mult_product[31:0];
      end
      if (!flush && r_state == DIV_WAIT && div_done) begin
        r_hi <= div_remainder;
        r_lo <= div_quotient;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - randomized self-checking bench for muldiv_sched
// Unit models respond after a chosen latency; expected HI/LO and timing come from plain arithmetic.
module tb_muldiv_sched;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = 32'd0, req_src2 = 32'd0;
  logic        mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic [63:0] mult_product = 64'd0;
  logic        mult_end = 1'b0;
  logic        div_start, div_signed;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient = 32'd0, div_remainder = 32'd0;
  logic        div_done = 1'b0;
  logic        flush = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_hi, rsp_lo;
  logic        busy, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
    .mult_product(mult_product), .mult_end(mult_end),
    .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ua, ub;
    logic [31:0] q, r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 2'b11) return {a, b};
    if (op == 2'b00) return ua * ub;
    if (b == 32'd0)  return {a, 32'hFFFF_FFFF};
    if (op == 2'b01) return {a % b, a / b};
    q = 32'($signed(a) / $signed(b));
    r = 32'($signed(a) % $signed(b));
    return {r, q};
  endfunction

  // lat = cycles the unit takes from start (0 = never completes); hold = cycles of rsp_ready low.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int hold);
    logic [63:0] exp;
    bit imm, is_div, gets_rsp;
    int exp_starts, mcnt, dcnt, cyc, rsp_cyc, done_cyc, terr_cyc;
    exp        = ref_hilo(op, a, b);
    is_div     = (op == 2'b01 || op == 2'b10) && b != 32'd0;
    imm        = (op == 2'b11) || ((op == 2'b01 || op == 2'b10) && b == 32'd0);
    gets_rsp   = imm || lat != 0;
    exp_starts = imm ? 0 : (lat != 0 ? lat : TO);
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    mcnt = 0; dcnt = 0; cyc = 0; rsp_cyc = -1; done_cyc = -1; terr_cyc = -1;
    while (rsp_cyc < 0 && terr_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; req_op = 2'($urandom); req_src1 = $urandom; req_src2 = $urandom;
      if (cyc == 1) check_eq("busy_after_accept", busy, 1);
      if (rsp_valid) rsp_cyc = cyc;
      if (timeout_err) terr_cyc = cyc;
      mult_end = 1'b0; div_done = 1'b0;
      mult_product = {$urandom, $urandom}; div_quotient = $urandom; div_remainder = $urandom;
      if (mult_begin) begin
        mcnt++;
        if (mcnt == 1) check_eq("mult_operands", {mult_op1, mult_op2}, {a, b});
        div_done = 1'($urandom_range(0, 1));
        if (lat != 0 && mcnt == lat) begin
          mult_end = 1'b1; mult_product = exp; done_cyc = cyc;
        end
      end
      if (div_start) begin
        dcnt++;
        if (dcnt == 1) begin
          check_eq("div_operands", {div_dividend, div_divisor}, {a, b});
          check_eq("div_signed", div_signed, (op == 2'b10));
        end
        mult_end = 1'($urandom_range(0, 1));
        if (lat != 0 && dcnt == lat) begin
          div_done = 1'b1; div_remainder = exp[63:32]; div_quotient = exp[31:0]; done_cyc = cyc;
        end
      end
    end
    mult_end = 1'b0; div_done = 1'b0;
    check_eq("op_within_budget", cyc < 60, 1);
    check_eq("mult_start_cycles", mcnt, (op == 2'b00) ? exp_starts : 0);
    check_eq("div_start_cycles", dcnt, is_div ? exp_starts : 0);
    if (gets_rsp) begin
      check_eq("rsp_latency", rsp_cyc, imm ? 1 : done_cyc + 1);
      check_eq("rsp_data", {rsp_hi, rsp_lo}, exp);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_eq("rsp_held_valid", rsp_valid, 1);
        check_eq("rsp_held_data", {rsp_hi, rsp_lo}, exp);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("idle_after_rsp", {busy, rsp_valid, req_ready}, 3'b001);
    end else begin
      check_eq("timeout_cycle", terr_cyc, TO + 1);
      check_eq("timeout_no_rsp", {rsp_cyc == -1, busy}, 2'b10);
      @(negedge clk);
      check_eq("timeout_single_pulse", {timeout_err, rsp_valid, req_ready}, 3'b001);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("reset_ctrl", {req_ready, busy, rsp_valid, mult_begin, div_start, timeout_err, div_signed},
             7'b1000000);
    check_eq("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
    check_eq("reset_ops", {mult_op1, mult_op2, div_dividend, div_divisor}, 128'd0);
    @(negedge clk);

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 4, 3);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 3, 0);
    do_op(2'b01, 32'd7, 32'd0, 5, 1);
    do_op(2'b00, 32'h1, 32'h2, 0, 0);
    do_op(2'b11, 32'h1234, 32'h5678, 3, 0);
    do_op(2'b01, 32'd1000, 32'd7, TO, 0);

    // Flush in the second DIV_WAIT cycle, colliding with div_done.
    req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd100; req_src2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("flush_div_started", div_start, 1);
    @(negedge clk);
    flush = 1'b1; div_done = 1'b1; div_quotient = 32'hDEAD; div_remainder = 32'hBEEF;
    @(negedge clk);
    div_done = 1'b0;
    check_eq("flush_to_idle", {busy, div_start, rsp_valid, req_ready}, 4'b0000);
    req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'h1234; req_src2 = 32'h5678;
    @(negedge clk);
    check_eq("flush_blocks_req", {busy, rsp_valid}, 2'b00);
    flush = 1'b0;
    #1;
    check_eq("ready_after_flush", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("post_flush_rsp", {rsp_valid, mult_begin, div_start}, 3'b100);
    check_eq("post_flush_data", {rsp_hi, rsp_lo}, 64'h0000_1234_0000_5678);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_flush_idle", busy, 0);

    // Asynchronous reset in the middle of a multiply.
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mult_running", mult_begin, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_reset", {busy, mult_begin, rsp_valid, req_ready}, 4'b0001);
    check_eq("async_reset_ops", {mult_op1, mult_op2}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          lat;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat = $urandom_range(0, TO);
      do_op(op, a, b, lat, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
